// File: rtl/avalon_bus_arbiter.sv
// Two-master, one-slave Avalon-MM arbiter. It grants round-robin and holds a grant for one
// whole transaction. A sticky watchdog flags a slave that stalls too long.
module avalon_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,

    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,

    output logic [1:0]          grant,
    output logic                timeout_err,
    output logic [1:0]          dbg_state
);

    // Handshake: a master holds read/write with stable address/data until it sees
    // waitrequest low. That cycle is the single data/ack cycle. A waitrequest of 1
    // means the master is stalled and the master must not sample readdata.

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_SET = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t             state;
    logic               last_owner;
    logic [CNT_W-1:0]   wait_cnt;
    logic               m0_req;
    logic               m1_req;

    assign m0_req    = m0_read | m0_write;
    assign m1_req    = m1_read | m1_write;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            grant       <= 2'b00;
            last_owner  <= 1'b1;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // On a tie, the master that did not own the bus last time wins.
                    if (m0_req && (!m1_req || last_owner)) begin
                        state    <= GNT0;
                        grant    <= 2'b01;
                        wait_cnt <= '0;
                    end else if (m1_req) begin
                        state    <= GNT1;
                        grant    <= 2'b10;
                        wait_cnt <= '0;
                    end
                end
                GNT0: begin
                    if (!m0_req || !s_waitrequest) begin
                        state      <= IDLE;
                        grant      <= 2'b00;
                        last_owner <= 1'b0;
                    end
                end
                GNT1: begin
                    if (!m1_req || !s_waitrequest) begin
                        state      <= IDLE;
                        grant      <= 2'b00;
                        last_owner <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase

            // The watchdog only observes. It does not abort the transaction, and the count saturates.
            if (state != IDLE && s_waitrequest) begin
                if (wait_cnt != TMO_MAX)
                    wait_cnt <= wait_cnt + 1'b1;
                if (wait_cnt >= TMO_SET)
                    timeout_err <= 1'b1;
            end
        end
    end

    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m0_readdata    = s_readdata;
        m1_readdata    = s_readdata;
        case (state)
            GNT0: begin
                s_address      = m0_address;
                s_write        = m0_write;
                s_read         = m0_read & ~m0_write;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                m0_waitrequest = s_waitrequest;
            end
            GNT1: begin
                s_address      = m1_address;
                s_write        = m1_write;
                s_read         = m1_read & ~m1_write;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Directed bench for avalon_bus_arbiter. It uses TIMEOUT=4 so the watchdog can be reached.
// Inputs change 2 time units after the rising edge, and outputs are sampled 1 unit later.
module tb_avalon_bus_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] m0_address,  m1_address;
    logic              m0_read,     m1_read;
    logic              m0_write,    m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata;
    logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic [ADDR_W-1:0] s_address;
    logic              s_read, s_write;
    logic [DATA_W-1:0] s_writedata;
    logic [BE_W-1:0]   s_byteenable;
    logic              s_waitrequest;
    logic [DATA_W-1:0] s_readdata;
    logic [1:0]        grant;
    logic              timeout_err;
    logic [1:0]        dbg_state;

    int errors = 0;
    int checks = 0;

    avalon_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(grant), .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 1'b0; s_readdata = '0;

        // Reset with both masters idle
        tick();
        settle();
        check("rst_grant",   64'(grant),          64'h0);
        check("rst_s_read",  64'(s_read),         64'h0);
        check("rst_s_write", 64'(s_write),        64'h0);
        check("rst_m0_wait", 64'(m0_waitrequest), 64'h1);
        check("rst_m1_wait", 64'(m1_waitrequest), 64'h1);
        check("rst_tmo",     64'(timeout_err),    64'h0);
        check("rst_state",   64'(dbg_state),      64'h0);
        tick();
        reset = 1'b1;

        // m0 single read with a zero-wait slave
        tick();
        m0_address = 32'h0000_0004; m0_read = 1'b1;
        s_waitrequest = 1'b0; s_readdata = 32'h240A_0001;
        settle();
        check("rd_c1_grant",  64'(grant),          64'h0);
        check("rd_c1_s_read", 64'(s_read),         64'h0);
        check("rd_c1_m0wait", 64'(m0_waitrequest), 64'h1);
        tick();
        check("rd_c2_grant",  64'(grant),          64'h1);
        check("rd_c2_addr",   64'(s_address),      64'h4);
        check("rd_c2_s_read", 64'(s_read),         64'h1);
        check("rd_c2_rdata",  64'(m0_readdata),    64'h240A_0001);
        check("rd_c2_m0wait", 64'(m0_waitrequest), 64'h0);
        check("rd_c2_m1wait", 64'(m1_waitrequest), 64'h1);
        tick();
        m0_read = 1'b0;
        settle();
        check("rd_c3_grant",  64'(grant),          64'h0);
        check("rd_c3_s_read", 64'(s_read),         64'h0);

        // Both masters request continuously from reset: 01,00,10,00,01,00,10,00
        do_reset();
        m0_read = 1'b1; m0_address = 32'h10;
        m1_read = 1'b1; m1_address = 32'h20;
        s_waitrequest = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [1:0] exp_g;
            tick();
            settle();
            case (i % 4)
                0: exp_g = 2'b01;
                2: exp_g = 2'b10;
                default: exp_g = 2'b00;
            endcase
            check($sformatf("rr_grant_%0d", i), 64'(grant), 64'(exp_g));
            if (exp_g == 2'b10)
                check($sformatf("rr_addr_%0d", i), 64'(s_address), 64'h20);
        end
        m0_read = 1'b0; m1_read = 1'b0;

        // m1 write with a 3-cycle stall while m0 requests
        tick();
        m1_address = 32'h100; m1_write = 1'b1;
        m1_writedata = 32'hDEAD_BEEF; m1_byteenable = 4'hF;
        s_waitrequest = 1'b1;
        tick();
        m0_read = 1'b1; m0_address = 32'h44;
        settle();
        check("wr_grant",   64'(grant),          64'h2);
        check("wr_s_write", 64'(s_write),        64'h1);
        check("wr_addr",    64'(s_address),      64'h100);
        check("wr_wdata",   64'(s_writedata),    64'hDEAD_BEEF);
        check("wr_be",      64'(s_byteenable),   64'hF);
        check("wr_m1wait",  64'(m1_waitrequest), 64'h1);
        check("wr_m0wait1", 64'(m0_waitrequest), 64'h1);
        for (int k = 2; k <= 4; k++) begin
            tick();
            if (k == 4) s_waitrequest = 1'b0;
            settle();
            check($sformatf("wr_grant_c%0d", k), 64'(grant),          64'h2);
            check($sformatf("wr_m0wait_c%0d", k), 64'(m0_waitrequest), 64'h1);
            check($sformatf("wr_m1wait_c%0d", k), 64'(m1_waitrequest), (k == 4) ? 64'h0 : 64'h1);
        end
        tick();
        m1_write = 1'b0;
        settle();
        check("wr_idle_grant",  64'(grant),          64'h0);
        check("wr_idle_m0wait", 64'(m0_waitrequest), 64'h1);
        tick();
        check("wr_m0_grant",    64'(grant),          64'h1);
        check("wr_m0_addr",     64'(s_address),      64'h44);
        check("wr_no_tmo",      64'(timeout_err),    64'h0);
        tick();
        m0_read = 1'b0;
        settle();
        check("wr_end_grant",   64'(grant),          64'h0);

        // m0 read with a 6-cycle stall: the watchdog trips after the 4th stalled cycle
        tick();
        m0_read = 1'b1; m0_address = 32'h80;
        s_waitrequest = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            settle();
            check($sformatf("tmo_grant_c%0d", k), 64'(grant),          64'h1);
            check($sformatf("tmo_wait_c%0d", k),  64'(m0_waitrequest), 64'h1);
            check($sformatf("tmo_err_c%0d", k),   64'(timeout_err),    (k >= 5) ? 64'h1 : 64'h0);
        end
        tick();
        s_waitrequest = 1'b0; s_readdata = 32'h1234_5678;
        settle();
        check("tmo_done_grant", 64'(grant),          64'h1);
        check("tmo_done_wait",  64'(m0_waitrequest), 64'h0);
        check("tmo_done_rdata", 64'(m0_readdata),    64'h1234_5678);
        tick();
        m0_read = 1'b0;
        settle();
        check("tmo_idle_grant", 64'(grant),       64'h0);
        check("tmo_idle_err",   64'(timeout_err), 64'h1);
        tick();
        check("tmo_sticky",     64'(timeout_err), 64'h1);

        // Reset asserted during a GNT1 stall
        m1_write = 1'b1; m1_address = 32'h200; m1_writedata = 32'h5;
        s_waitrequest = 1'b1;
        tick();
        settle();
        check("mr_grant",   64'(grant),   64'h2);
        check("mr_s_write", 64'(s_write), 64'h1);
        reset = 1'b0;
        settle();
        check("mr_rst_grant",  64'(grant),          64'h0);
        check("mr_rst_s_write", 64'(s_write),       64'h0);
        check("mr_rst_m1wait", 64'(m1_waitrequest), 64'h1);
        check("mr_rst_err",    64'(timeout_err),    64'h0);
        m0_read = 1'b1; m0_address = 32'h300;
        s_waitrequest = 1'b0;
        tick();
        reset = 1'b1;
        settle();
        check("mr_rel_grant", 64'(grant), 64'h0);
        tick();
        check("mr_first_grant", 64'(grant),     64'h1);
        check("mr_first_addr",  64'(s_address), 64'h300);
        m0_read = 1'b0; m1_write = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/avalon_bus_arbiter.md
Name: avalon_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the CPU's Avalon memory-mapped bus.
- Master 0 is the CPU's bus controller. Master 1 is a secondary requester, such as a program loader or debug port.
- The single slave is the shared RAM.
- Grants are round-robin and locked for one whole transaction. A watchdog flags slave stalls.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (byteenable width is DATA_W/8).
- TIMEOUT, 255, maximum waitrequest-high cycles tolerated on a granted transaction; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_address  in  ADDR_W  master 0 address.
- m0_read  in  1  master 0 read request.
- m0_write  in  1  master 0 write request.
- m0_writedata  in  DATA_W  master 0 write data.
- m0_byteenable  in  DATA_W/8  master 0 byte enables.
- m0_waitrequest  out  1  stall to master 0.
- m0_readdata  out  DATA_W  read data to master 0.
- m1_*  same set as m0_*, for master 1.
- s_address  out  ADDR_W  to slave.
- s_read  out  1  to slave.
- s_write  out  1  to slave.
- s_writedata  out  DATA_W  to slave.
- s_byteenable  out  DATA_W/8  to slave.
- s_waitrequest  in  1  slave stall.
- s_readdata  in  DATA_W  slave read data.
- grant  out  2  one-hot current owner; 00 when idle.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- States: IDLE, GNT0, GNT1. State, grant, last_owner, the wait counter and timeout_err are registers; all other outputs are combinational from state.
- Request: mN_req = mN_read | mN_write.
- Reset (asynchronous assert, synchronous-safe deassert):
  - state=IDLE, grant=00, last_owner=1 (so master 0 wins the first tie), counter=0, timeout_err=0.
  - All s_* outputs are 0; both mN_waitrequest are 1.
- IDLE:
  - Slave outputs are 0; both waitrequests are 1.
  - Only one master requesting: go to that master's GNT state next edge.
  - Both requesting: grant the master that is not last_owner.
  - No request: stay in IDLE.
- GNTn, forwarding:
  - s_address, s_writedata and s_byteenable follow master n.
  - If master n drives read and write together, s_write=mN_write and s_read=0 (write wins).
- GNTn, stall handling:
  - mN_waitrequest = s_waitrequest.
  - The other master's waitrequest is held at 1.
  - s_readdata is routed to both readdata outputs; only the granted master may sample it.
- Completion: s_waitrequest=0 while master n's request is high. That cycle is the data/ack cycle. Next edge: state=IDLE, last_owner=n.
- Withdrawal: master n drops its request while granted (protocol violation). Return to IDLE next edge, last_owner=n.
- Latency: minimum 2 cycles per transaction (1 arbitration cycle + 1 slave cycle). There is always one IDLE bubble between transactions, so a master cannot be granted twice back-to-back while the other requests.
- Watchdog:
  - The counter clears on entering GNTn and increments each GNTn cycle with s_waitrequest=1.
  - When the counter reaches TIMEOUT, timeout_err sets and holds until reset.
  - The transaction is not aborted; the counter saturates.
- A request arriving mid-transaction from the non-owner is only considered in the next IDLE cycle.
- A reset asserted mid-transaction forces the reset values immediately; the slave sees read/write drop asynchronously.

Test Plan:
- Reset with both masters idle → grant=00, s_read=s_write=0, m0/m1_waitrequest=1, timeout_err=0.
- m0 reads 0x00000004, slave zero-wait returning 0x240A0001 → cycle 1 IDLE, cycle 2 grant=01, s_address=0x4, m0_readdata=0x240A0001, m0_waitrequest=0, then IDLE.
- m0 and m1 both request continuously from reset (zero-wait slave) → grants alternate 01, 10, 01, 10 with one IDLE cycle between each; m0 is served first.
- m1 write of 0xDEADBEEF, byteenable=0xF, to 0x100 while the slave stalls 3 cycles; m0 requests during the stall → m1 stays granted for 4 GNT1 cycles, m0_waitrequest=1 throughout, then m0 is granted after IDLE.
- TIMEOUT=4 and the slave holds waitrequest=1 for 6 cycles on an m0 read → timeout_err rises once the count reaches 4, the transaction still completes, and timeout_err stays 1 after return to IDLE until reset.
- reset asserted during a GNT1 stall → grant=00 and s_write=0 immediately; after release, both requesting → m0 is granted first.
